// File: rtl/group_mac_acc_if.sv
// Purpose: beat/result bus of group_mac_acc, bundling the lane operands and the windowed results.
// Latency: none; this file holds wires only.
// Backpressure: none. The source streams one beat per clock and the result is a one-cycle pulse.
// Ports:
//   img/ker             packed lane operands, with lane 0 in the LSBs.
//   val/last/relu_en    beat qualifiers.
//   result/result_val/overflow  windowed outputs.
interface group_mac_acc_if #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 8,
  parameter int OUT_WIDTH = 16
);
  logic [GROUP_NB*IMG_WIDTH-1:0] img;
  logic [GROUP_NB*KER_WIDTH-1:0] ker;
  logic                          val;
  logic                          last;
  logic                          relu_en;
  logic [GROUP_NB*OUT_WIDTH-1:0] result;
  logic                          result_val;
  logic [GROUP_NB-1:0]           overflow;

  modport master (output img, ker, val, last, relu_en,
                  input  result, result_val, overflow);
  modport slave  (input  img, ker, val, last, relu_en,
                  output result, result_val, overflow);
endinterface

// File: rtl/group_mac_acc.sv
// Purpose: GROUP_NB signed MAC lanes that accumulate over a window closed by last.
//          At window close they round, rescale, apply optional ReLU and saturate.
// Latency: when the last beat is sampled at edge k, result_val is high for the cycle after edge k+1.
// Backpressure: none. The block accepts one beat per clock and a new window may follow last immediately.
// Ports:
//   clk, rst   clock and asynchronous active-high reset.
//   bus        slave side of group_mac_acc_if, carrying the operands in and the results out.
module group_mac_acc #(
  parameter int GROUP_NB  = 4,
  parameter int IMG_WIDTH = 16,
  parameter int IMG_FIXED = 4,
  parameter int KER_WIDTH = 8,
  parameter int KER_FIXED = 4,
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = KER_FIXED
) (
  input logic             clk,
  input logic             rst,
  group_mac_acc_if.slave  bus
);
  localparam int PW    = IMG_WIDTH + KER_WIDTH;
  // The inner conditional keeps the shift amount legal when SHIFT is 0.
  localparam int RND_I = (SHIFT > 0) ? (1 << ((SHIFT > 0) ? SHIFT - 1 : 0)) : 0;
  localparam logic signed [ACC_WIDTH:0] RND = (ACC_WIDTH+1)'(RND_I);

  if (ACC_WIDTH < PW) begin : g_bad_acc
    $error("ACC_WIDTH must hold a full product");
  end
  if (IMG_FIXED >= IMG_WIDTH) begin : g_bad_fmt
    $error("IMG_FIXED must be below IMG_WIDTH");
  end

  logic val_d1, last_d1, relu_d1;
  logic start;   // the next accepted beat opens a fresh window
  logic rv_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_d1  <= 1'b0;
      last_d1 <= 1'b0;
      relu_d1 <= 1'b0;
      start   <= 1'b1;
      rv_q    <= 1'b0;
    end else begin
      val_d1  <= bus.val;
      last_d1 <= bus.last & bus.val;
      relu_d1 <= bus.relu_en;
      if (val_d1) start <= last_d1;
      rv_q    <= val_d1 & last_d1;
    end
  end

  assign bus.result_val = rv_q;

  for (genvar i = 0; i < GROUP_NB; i++) begin : g_lane
    logic signed [IMG_WIDTH-1:0] img_l;
    logic signed [KER_WIDTH-1:0] ker_l;
    logic signed [PW-1:0]        prod_d1;
    logic signed [ACC_WIDTH-1:0] acc, base, sum;
    logic signed [ACC_WIDTH:0]   wide, rnd, shr;
    logic                        acc_ovf, acc_sat, ovf_next, osat;
    logic signed [OUT_WIDTH-1:0] r_next, res_q;
    logic                        ovf_q;

    assign img_l = bus.img[i*IMG_WIDTH +: IMG_WIDTH];
    assign ker_l = bus.ker[i*KER_WIDTH +: KER_WIDTH];

    always_comb begin
      base     = start ? '0 : acc;
      // Use one guard bit, so a sign mismatch in the top two bits means the accumulator saturated.
      wide     = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(prod_d1);
      acc_sat  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
      sum      = acc_sat ? {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}}
                         : wide[ACC_WIDTH-1:0];
      ovf_next = (~start & acc_ovf) | acc_sat;
      rnd      = (ACC_WIDTH+1)'(sum) + RND;
      shr      = rnd >>> SHIFT;
      if (relu_d1 && shr[ACC_WIDTH]) shr = '0;
      // The value fits in OUT_WIDTH when every bit above the output sign matches it.
      osat     = ~((&shr[ACC_WIDTH:OUT_WIDTH-1]) | ~(|shr[ACC_WIDTH:OUT_WIDTH-1]));
      r_next   = osat ? {shr[ACC_WIDTH], {(OUT_WIDTH-1){~shr[ACC_WIDTH]}}}
                      : shr[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        prod_d1 <= '0;
        acc     <= '0;
        acc_ovf <= 1'b0;
        res_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        prod_d1 <= PW'(img_l) * PW'(ker_l);
        if (val_d1) begin
          acc     <= sum;
          acc_ovf <= ovf_next;
        end
        if (val_d1 && last_d1) begin
          res_q <= r_next;
          ovf_q <= ovf_next | osat;
        end
      end
    end

    assign bus.result[i*OUT_WIDTH +: OUT_WIDTH] = res_q;
    assign bus.overflow[i] = ovf_q;
  end
endmodule

// File: tb/tb_group_mac_acc.sv
module tb_group_mac_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  group_mac_acc_if #(.GROUP_NB(4), .IMG_WIDTH(16), .KER_WIDTH(8), .OUT_WIDTH(16)) bus ();

  group_mac_acc dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic drive(input logic [63:0] img, input logic [31:0] ker,
                       input logic val, input logic last, input logic relu);
    bus.img = img; bus.ker = ker; bus.val = val; bus.last = last; bus.relu_en = relu;
  endtask

  // Advance to 1 time unit after the next rising edge, away from the sampling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(64'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Run a one-beat window and stop on the cycle where its result is expected.
  task automatic single_beat(input logic [63:0] img, input logic [31:0] ker, input logic relu);
    drive(img, ker, 1'b1, 1'b1, relu);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (bus.result_val !== 1'b0) begin miscompares++; $display("FAIL reset_val: got %b want 0", bus.result_val); end
    vectors++;
    if (bus.result !== 64'h0) begin miscompares++; $display("FAIL reset_result: got %h want 0", bus.result); end
    vectors++;
    if (bus.overflow !== 4'h0) begin miscompares++; $display("FAIL reset_ovf: got %h want 0", bus.overflow); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] img;
    for (int k = 0; k < 5; k++) begin
      for (int l = 0; l < 4; l++) img[l*16 +: 16] = 16'((4*k + l + 1) * 16);
      drive(img, 32'h08080808, 1'b1, (k == 4), 1'b0);
      tick();
    end
    idle();
    vectors++;
    if (bus.result_val !== 1'b0) begin miscompares++; $display("FAIL basic_early: got %b want 0", bus.result_val); end
    tick();
    vectors++;
    if (bus.result_val !== 1'b1) begin miscompares++; $display("FAIL basic_val: got %b want 1", bus.result_val); end
    vectors++;
    if (bus.result !== 64'h01E0_01B8_0190_0168) begin miscompares++; $display("FAIL basic_result: got %h want 01e001b801900168", bus.result); end
    vectors++;
    if (bus.overflow !== 4'h0) begin miscompares++; $display("FAIL basic_ovf: got %h want 0", bus.overflow); end
    tick();
    vectors++;
    if (bus.result_val !== 1'b0) begin miscompares++; $display("FAIL basic_pulse: got %b want 0", bus.result_val); end
    vectors++;
    if (bus.result !== 64'h01E0_01B8_0190_0168) begin miscompares++; $display("FAIL basic_hold: got %h want 01e001b801900168", bus.result); end
  endtask

  task automatic test_round_relu();
    single_beat({4{16'hFFF0}}, 32'h08080808, 1'b0);
    vectors++;
    if (bus.result !== {4{16'hFFF8}} || bus.result_val !== 1'b1) begin miscompares++; $display("FAIL neg_round: got %h/%b want fff8x4/1", bus.result, bus.result_val); end
    single_beat({4{16'hFFF0}}, 32'h08080808, 1'b1);
    vectors++;
    if (bus.result !== 64'h0 || bus.result_val !== 1'b1) begin miscompares++; $display("FAIL relu: got %h/%b want 0/1", bus.result, bus.result_val); end
    single_beat({4{16'h0001}}, 32'h08080808, 1'b0);
    vectors++;
    if (bus.result !== {4{16'h0001}}) begin miscompares++; $display("FAIL half_up: got %h want 0001x4", bus.result); end
  endtask

  task automatic test_saturation();
    single_beat({16'h0000, 16'h0010, 16'h8000, 16'h7FFF}, 32'h7F7F7F7F, 1'b0);
    vectors++;
    if (bus.result !== 64'h0000_007F_8000_7FFF) begin miscompares++; $display("FAIL sat_result: got %h want 0000007f80007fff", bus.result); end
    vectors++;
    if (bus.overflow !== 4'b0011) begin miscompares++; $display("FAIL sat_ovf: got %b want 0011", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    // Window A is three 1.0*1.0 beats with bubbles and a stray last on a bubble.
    drive({4{16'h0010}}, 32'h10101010, 1'b1, 1'b0, 1'b0); tick();
    drive({4{16'h7777}}, 32'h10101010, 1'b0, 1'b1, 1'b0); tick();
    drive({4{16'h0010}}, 32'h10101010, 1'b1, 1'b0, 1'b0); tick();
    idle(); tick();
    drive({4{16'h0010}}, 32'h10101010, 1'b1, 1'b1, 1'b0); tick();
    // Window B is two 2.0*1.0 beats that start right after A's last beat.
    drive({4{16'h0020}}, 32'h10101010, 1'b1, 1'b0, 1'b0); tick();
    vectors++;
    if (bus.result_val !== 1'b1 || bus.result !== {4{16'h0030}}) begin miscompares++; $display("FAIL win_a: got %h/%b want 0030x4/1", bus.result, bus.result_val); end
    drive({4{16'h0020}}, 32'h10101010, 1'b1, 1'b1, 1'b0); tick();
    vectors++;
    if (bus.result_val !== 1'b0) begin miscompares++; $display("FAIL win_gap: got %b want 0", bus.result_val); end
    idle(); tick();
    vectors++;
    if (bus.result_val !== 1'b1 || bus.result !== {4{16'h0040}}) begin miscompares++; $display("FAIL win_b: got %h/%b want 0040x4/1", bus.result, bus.result_val); end
  endtask

  task automatic test_mid_reset();
    drive({4{16'h0100}}, 32'h10101010, 1'b1, 1'b0, 1'b0); tick();
    drive({4{16'h0100}}, 32'h10101010, 1'b1, 1'b1, 1'b0); tick();
    idle();
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.result_val !== 1'b0 || bus.result !== 64'h0) begin miscompares++; $display("FAIL rst_async: got %h/%b want 0/0", bus.result, bus.result_val); end
    for (int c = 0; c < 2; c++) begin
      tick();
      vectors++;
      if (bus.result_val !== 1'b0) begin miscompares++; $display("FAIL rst_hold: got %b want 0", bus.result_val); end
    end
    rst = 1'b0;
    single_beat({4{16'h0010}}, 32'h10101010, 1'b0);
    vectors++;
    if (bus.result_val !== 1'b1 || bus.result !== {4{16'h0010}} || bus.overflow !== 4'h0) begin
      miscompares++; $display("FAIL rst_fresh: got %h/%b/%b want 0010x4/1/0", bus.result, bus.result_val, bus.overflow);
    end
  endtask

  task automatic test_last_no_val();
    int seen;
    seen = 0;
    drive({4{16'h0010}}, 32'h10101010, 1'b1, 1'b0, 1'b0); tick();
    for (int c = 0; c < 3; c++) begin
      drive({4{16'h0010}}, 32'h10101010, 1'b0, 1'b1, 1'b0); tick();
      if (bus.result_val === 1'b1) seen++;
    end
    idle(); tick();
    if (bus.result_val === 1'b1) seen++;
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL last_noval: got %0d pulses want 0", seen); end
    single_beat({4{16'h0010}}, 32'h10101010, 1'b0);
    vectors++;
    if (bus.result_val !== 1'b1 || bus.result !== {4{16'h0020}}) begin miscompares++; $display("FAIL last_real: got %h/%b want 0020x4/1", bus.result, bus.result_val); end
  endtask

  initial begin
    idle();
    test_reset();
    test_basic();
    test_round_relu();
    test_saturation();
    test_back_to_back();
    test_mid_reset();
    test_last_no_val();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
